// File: rtl/dt_batch_scheduler.sv
// Batch sequencer for the decision-tree core: one start per sample, fresh-edge done capture, result stream and per-class tallies.
// Optional DT_WATCHDOG_EN adds a per-sample timeout that reports class 3 and raises a sticky timeout_err.
module dt_batch_scheduler #(
  parameter int IDX_W       = 8,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             batch_start,
  input  logic [IDX_W-1:0] num_samples,
  input  logic             abort,
  output logic             dt_start,
  output logic [IDX_W-1:0] dt_sample_idx,
  input  logic [1:0]       dt_class,
  input  logic             dt_done,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic [1:0]       res_class,
  output logic [CNT_W-1:0] cnt_c0,
  output logic [CNT_W-1:0] cnt_c1,
  output logic [CNT_W-1:0] cnt_c2,
  output logic [CNT_W-1:0] cnt_c3,
  output logic             busy,
  output logic             batch_done
`ifdef DT_WATCHDOG_EN
  ,
  output logic             timeout_err
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, num_q;
  logic             done_q;
  logic             zero_done_q;
  logic             tmo_q;
  logic [CNT_W-1:0] cnt [4];
  logic             fresh_done;
  logic             last;
  logic             accept;
  logic             wdog_exp;

  assign fresh_done = dt_done & ~done_q;
  assign last       = (idx == num_q - 1'b1);
  assign accept     = (state == IDLE) && batch_start;

`ifdef DT_WATCHDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WD_W-1:0] wdog;

  assign wdog_exp = (wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        wdog <= '0;
      end else if (state == WAIT) begin
        wdog <= wdog + 1'b1;
      end
      if (accept) begin
        timeout_err <= 1'b0;
      end else if (state == WAIT && !fresh_done && wdog_exp && !abort) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (batch_start && num_samples != '0) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (fresh_done || wdog_exp) state_nxt = STORE;
      STORE:   state_nxt = last ? DONE : LAUNCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition, including the STORE report.
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  assign dt_start      = (state == LAUNCH) && !abort;
  assign res_valid     = (state == STORE) && !abort;
  assign batch_done    = ((state == DONE) && !abort) || zero_done_q;
  assign busy          = (state != IDLE);
  assign dt_sample_idx = idx;
  assign cnt_c0        = cnt[0];
  assign cnt_c1        = cnt[1];
  assign cnt_c2        = cnt[2];
  assign cnt_c3        = cnt[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      num_q       <= '0;
      done_q      <= 1'b0;
      zero_done_q <= 1'b0;
      tmo_q       <= 1'b0;
      res_idx     <= '0;
      res_class   <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      state       <= state_nxt;
      done_q      <= dt_done;
      zero_done_q <= accept && (num_samples == '0);
      if (accept) begin
        num_q     <= num_samples;
        idx       <= '0;
        res_idx   <= '0;
        res_class <= '0;
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end
      if (state == WAIT && state_nxt == STORE) begin
        res_idx   <= idx;
        res_class <= fresh_done ? dt_class : 2'b11;
        tmo_q     <= !fresh_done;
      end
      // Timed-out samples are reported but never tallied.
      if (state == STORE && !abort) begin
        if (!tmo_q && cnt[res_class] != '1) cnt[res_class] <= cnt[res_class] + 1'b1;
        if (!last) idx <= idx + 1'b1;
      end
    end
  end

endmodule
